// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage operand path: default width,
// register-index width helper and forward-select encodings.
package pipe_pkg;

   localparam int XLEN_DEF = 32;

   // Operand source select driven to the forward muxes
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,   // register file / WB write-through
      FWD_EX  = 2'd1,   // ALU result of instruction in EX
      FWD_MEM = 2'd2,   // ALU result of instruction in MEM
      FWD_MO  = 2'd3    // load data returning in MEM
   } fwd_sel_e;

   // Register index width; a single register still needs one bit
   function automatic int aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_regfile.sv
// Architectural register file: one write port, two write-through read
// ports; register 0 is hard-wired to zero.
module pipe_regfile
   import pipe_pkg::*;
#(
   parameter  int XLEN = XLEN_DEF,
   parameter  int NREG = 32,
   localparam int AW   = aw(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wdst,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   ra_idx,
   input  logic [AW-1:0]   rb_idx,
   output logic [XLEN-1:0] ra_data,
   output logic [XLEN-1:0] rb_data
);

   logic [XLEN-1:0] regs [NREG];

   // Rising-edge write; r0 is never written so it always reads zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && wdst != '0) begin
         regs[wdst] <= wdata;
      end
   end

   // Same-cycle write is visible to the reader (write-through)
   assign ra_data = (ra_idx == '0) ? '0 :
                    (we && wdst == ra_idx) ? wdata : regs[ra_idx];
   assign rb_data = (rb_idx == '0) ? '0 :
                    (we && wdst == rb_idx) ? wdata : regs[rb_idx];

endmodule

// File: rtl/pipe_id_operand.sv
// ID-stage operand path: register file, EX/MEM/WB forwarding, load-use
// interlock for variable-latency loads and the ID/EX operand latch.
module pipe_id_operand
   import pipe_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREG  = 32,
   parameter  int CNT_W = 16,
   localparam int AW    = aw(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [AW-1:0]    id_dst,
   input  logic             id_wreg,
   input  logic             id_m2reg,
   input  logic             ex_valid,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [AW-1:0]    ex_dst,
   input  logic [XLEN-1:0]  ex_alu,
   input  logic             mem_valid,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [AW-1:0]    mem_dst,
   input  logic [XLEN-1:0]  mem_alu,
   input  logic [XLEN-1:0]  mem_mo,
   input  logic             mem_mo_valid,
   input  logic             wb_wreg,
   input  logic [AW-1:0]    wb_dst,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ex_stall,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic [XLEN-1:0]  d_a,
   output logic [XLEN-1:0]  d_b,
   output logic             rsrtequ,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             id_hold,
   output logic             e_valid,
   output logic             e_wreg,
   output logic             e_m2reg,
   output logic [XLEN-1:0]  e_a,
   output logic [XLEN-1:0]  e_b,
   output logic [AW-1:0]    e_dst,
   output logic [CNT_W-1:0] hz_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Index 0 = rs, index 1 = rt
   logic [1:0][AW-1:0]   src_idx;
   logic [1:0]           src_used;
   logic [1:0][XLEN-1:0] rf_val;
   logic [1:0][XLEN-1:0] fwd_val;
   logic [1:0]           src_hz;
   fwd_sel_e             sel [2];
   logic                 hz;

   assign src_idx  = {id_rt, id_rs};
   assign src_used = {id_rt_used, id_rs_used};

   pipe_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_wreg),
      .wdst    (wb_dst),
      .wdata   (wb_data),
      .ra_idx  (id_rs),
      .rb_idx  (id_rt),
      .ra_data (rf_val[0]),
      .rb_data (rf_val[1])
   );

   // Per-source forward select and hazard detection; EX beats MEM beats RF.
   // A load still in EX cannot forward, so it falls through and only stalls.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         sel[s]     = FWD_RF;
         fwd_val[s] = rf_val[s];
         src_hz[s]  = 1'b0;
         if (src_used[s] && src_idx[s] != '0) begin
            if (ex_valid && ex_wreg && !ex_m2reg && ex_dst == src_idx[s]) begin
               sel[s]     = FWD_EX;
               fwd_val[s] = ex_alu;
            end else if (mem_valid && mem_wreg && mem_dst == src_idx[s]) begin
               sel[s]     = mem_m2reg ? FWD_MO : FWD_MEM;
               fwd_val[s] = mem_m2reg ? mem_mo : mem_alu;
            end
            src_hz[s] = (ex_valid && ex_wreg && ex_m2reg && ex_dst == src_idx[s]) ||
                        (mem_valid && mem_wreg && mem_m2reg &&
                         mem_dst == src_idx[s] && !mem_mo_valid);
         end
      end
   end

   assign d_a     = fwd_val[0];
   assign d_b     = fwd_val[1];
   assign fwd_a   = sel[0];
   assign fwd_b   = sel[1];
   assign rsrtequ = (fwd_val[0] == fwd_val[1]);
   assign hz      = id_valid && (|src_hz);
   assign id_hold = hz || ex_stall;

   // ID/EX latch: stall holds, flush or interlock inserts a bubble, else advance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_valid <= 1'b0;
         e_wreg  <= 1'b0;
         e_m2reg <= 1'b0;
         e_a     <= '0;
         e_b     <= '0;
         e_dst   <= '0;
      end else if (ex_stall && !flush) begin
         // EX busy: everything stays put
      end else if (flush || hz) begin
         e_valid <= 1'b0;
         e_wreg  <= 1'b0;
         e_m2reg <= 1'b0;
      end else begin
         e_valid <= id_valid;
         e_wreg  <= id_valid && id_wreg;
         e_m2reg <= id_valid && id_m2reg;
         e_a     <= fwd_val[0];
         e_b     <= fwd_val[1];
         e_dst   <= id_dst;
      end
   end

   // Count interlock bubbles actually inserted; clear beats increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hz_cnt <= '0;
      end else if (cnt_clr) begin
         hz_cnt <= '0;
      end else if (hz && !flush && !ex_stall && hz_cnt != CNT_MAX) begin
         hz_cnt <= hz_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_id_operand.sv
// Bench for pipe_id_operand: directed scenarios with literal expectations
// followed by random traffic, all cross-checked every cycle against a
// behavioural model of the operand path.
module tb_pipe_id_operand;
   import pipe_pkg::*;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg;
   logic [AW-1:0] id_rs, id_rt, id_dst, ex_dst, mem_dst, wb_dst;
   logic ex_valid, ex_wreg, ex_m2reg, mem_valid, mem_wreg, mem_m2reg, mem_mo_valid;
   logic [XLEN-1:0] ex_alu, mem_alu, mem_mo, wb_data;
   logic wb_wreg, ex_stall, flush, cnt_clr;

   logic [XLEN-1:0] d_a, d_b, e_a, e_b;
   logic rsrtequ, id_hold, e_valid, e_wreg, e_m2reg;
   logic [1:0] fwd_a, fwd_b;
   logic [AW-1:0] e_dst;
   logic [15:0] hz_cnt;

   logic [XLEN-1:0] d_a2, d_b2, e_a2, e_b2;
   logic rsrtequ2, id_hold2, e_valid2, e_wreg2, e_m2reg2;
   logic [1:0] fwd_a2, fwd_b2;
   logic [AW-1:0] e_dst2;
   logic [1:0] hz_cnt2;

   always #5 clk = ~clk;

   pipe_id_operand #(.XLEN(XLEN), .NREG(NREG), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
      .ex_m2reg(ex_m2reg), .ex_dst(ex_dst), .ex_alu(ex_alu), .mem_valid(mem_valid),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_dst(mem_dst), .mem_alu(mem_alu),
      .mem_mo(mem_mo), .mem_mo_valid(mem_mo_valid), .wb_wreg(wb_wreg), .wb_dst(wb_dst),
      .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .cnt_clr(cnt_clr),
      .d_a(d_a), .d_b(d_b), .rsrtequ(rsrtequ), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .id_hold(id_hold), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
      .e_a(e_a), .e_b(e_b), .e_dst(e_dst), .hz_cnt(hz_cnt));

   // Narrow-counter instance to exercise saturation
   pipe_id_operand #(.XLEN(XLEN), .NREG(NREG), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .ex_valid(ex_valid), .ex_wreg(ex_wreg),
      .ex_m2reg(ex_m2reg), .ex_dst(ex_dst), .ex_alu(ex_alu), .mem_valid(mem_valid),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_dst(mem_dst), .mem_alu(mem_alu),
      .mem_mo(mem_mo), .mem_mo_valid(mem_mo_valid), .wb_wreg(wb_wreg), .wb_dst(wb_dst),
      .wb_data(wb_data), .ex_stall(ex_stall), .flush(flush), .cnt_clr(cnt_clr),
      .d_a(d_a2), .d_b(d_b2), .rsrtequ(rsrtequ2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
      .id_hold(id_hold2), .e_valid(e_valid2), .e_wreg(e_wreg2), .e_m2reg(e_m2reg2),
      .e_a(e_a2), .e_b(e_b2), .e_dst(e_dst2), .hz_cnt(hz_cnt2));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [XLEN-1:0] m_rf [NREG];
   logic            m_ev, m_ew, m_em;
   logic [XLEN-1:0] m_ea, m_eb;
   logic [AW-1:0]   m_ed;
   int              m_cnt, m_cnt2;

   logic [1:0]      x_fa, x_fb;
   logic [XLEN-1:0] x_va, x_vb;
   logic            x_ha, x_hb, x_hz;

   function automatic logic [XLEN-1:0] rf_view(input logic [AW-1:0] r);
      if (r == 0) return '0;
      if (wb_wreg && wb_dst == r) return wb_data;
      return m_rf[r];
   endfunction

   // What one source operand must see, and whether it must wait
   function automatic void src_model(input logic [AW-1:0] r, input logic u,
                                     output logic [1:0] f, output logic [XLEN-1:0] v,
                                     output logic h);
      bit ex_writes, ex_alu_ok, mem_writes;
      f = 2'd0;
      v = rf_view(r);
      h = 1'b0;
      if (!u || r == 0) return;
      ex_writes  = ex_valid && ex_wreg && ex_dst == r;
      ex_alu_ok  = ex_writes && !ex_m2reg;
      mem_writes = mem_valid && mem_wreg && mem_dst == r;
      if (ex_alu_ok) begin
         f = 2'd1; v = ex_alu;
      end else if (mem_writes) begin
         f = mem_m2reg ? 2'd3 : 2'd2;
         v = mem_m2reg ? mem_mo : mem_alu;
      end
      h = (ex_writes && ex_m2reg) || (mem_writes && mem_m2reg && !mem_mo_valid);
   endfunction

   always_comb begin
      src_model(id_rs, id_rs_used, x_fa, x_va, x_ha);
      src_model(id_rt, id_rt_used, x_fb, x_vb, x_hb);
      x_hz = id_valid && (x_ha || x_hb);
   end

   // Model state advance
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) m_rf[i] <= '0;
         m_ev <= 0; m_ew <= 0; m_em <= 0; m_ea <= '0; m_eb <= '0; m_ed <= '0;
         m_cnt <= 0; m_cnt2 <= 0;
      end else begin
         if (wb_wreg && wb_dst != 0) m_rf[wb_dst] <= wb_data;
         if (flush || (x_hz && !ex_stall)) begin
            m_ev <= 0; m_ew <= 0; m_em <= 0;
         end else if (!ex_stall) begin
            m_ev <= id_valid; m_ew <= id_valid & id_wreg; m_em <= id_valid & id_m2reg;
            m_ea <= x_va; m_eb <= x_vb; m_ed <= id_dst;
         end
         if (cnt_clr) begin
            m_cnt <= 0; m_cnt2 <= 0;
         end else if (x_hz && !flush && !ex_stall) begin
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
         end
      end
   end

   // Every-cycle comparison, away from the active edge
   always @(negedge clk) begin
      chk("cyc_d_a", d_a, x_va);
      chk("cyc_d_b", d_b, x_vb);
      chk("cyc_fwd_a", fwd_a, x_fa);
      chk("cyc_fwd_b", fwd_b, x_fb);
      chk("cyc_rsrtequ", rsrtequ, x_va == x_vb);
      chk("cyc_id_hold", id_hold, x_hz || ex_stall);
      chk("cyc_e_valid", e_valid, m_ev);
      chk("cyc_e_wreg", e_wreg, m_ew);
      chk("cyc_e_m2reg", e_m2reg, m_em);
      chk("cyc_e_a", e_a, m_ea);
      chk("cyc_e_b", e_b, m_eb);
      chk("cyc_e_dst", e_dst, m_ed);
      chk("cyc_hz_cnt", hz_cnt, m_cnt);
      chk("cyc_hz_cnt2", hz_cnt2, m_cnt2);
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
      id_dst = '0; id_wreg = 0; id_m2reg = 0;
      ex_valid = 0; ex_wreg = 0; ex_m2reg = 0; ex_dst = '0; ex_alu = '0;
      mem_valid = 0; mem_wreg = 0; mem_m2reg = 0; mem_dst = '0; mem_alu = '0;
      mem_mo = '0; mem_mo_valid = 0;
      wb_wreg = 0; wb_dst = '0; wb_data = '0;
      ex_stall = 0; flush = 0; cnt_clr = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs = AW'($urandom_range(0, 7)); id_rt = AW'($urandom_range(0, 7));
      id_rs_used = ($urandom_range(0, 3) != 0); id_rt_used = ($urandom_range(0, 3) != 0);
      id_dst = AW'($urandom_range(0, 7));
      id_wreg = $urandom_range(0, 1); id_m2reg = $urandom_range(0, 1);
      ex_valid = $urandom_range(0, 1); ex_wreg = $urandom_range(0, 1);
      ex_m2reg = $urandom_range(0, 1); ex_dst = AW'($urandom_range(0, 7));
      ex_alu = $urandom;
      mem_valid = $urandom_range(0, 1); mem_wreg = $urandom_range(0, 1);
      mem_m2reg = $urandom_range(0, 1); mem_dst = AW'($urandom_range(0, 7));
      mem_alu = $urandom; mem_mo = $urandom; mem_mo_valid = $urandom_range(0, 1);
      wb_wreg = $urandom_range(0, 1); wb_dst = AW'($urandom_range(0, 7));
      wb_data = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      ex_stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      idle();
      rst = 0;
      tick();
      rst = 1;
      #2;
      chk("rst_e_valid", e_valid, 0);
      chk("rst_hz_cnt", hz_cnt, 0);
      chk("rst_e_a", e_a, 0);

      // ALU result in EX forwarded to rs
      idle();
      ex_valid = 1; ex_wreg = 1; ex_dst = 3; ex_alu = 5;
      id_valid = 1; id_rs = 3; id_rs_used = 1;
      #2;
      chk("ex_fwd_sel", fwd_a, 1);
      chk("ex_fwd_val", d_a, 5);
      chk("ex_fwd_hold", id_hold, 0);

      // Load-use: exactly one bubble, then load data forwarded from MEM
      tick(); idle();
      ex_valid = 1; ex_wreg = 1; ex_m2reg = 1; ex_dst = 4;
      id_valid = 1; id_rs = 4; id_rs_used = 1; id_wreg = 1; id_dst = 5;
      #1;
      chk("lu_hold", id_hold, 1);
      tick();
      chk("lu_bubble", e_valid, 0);
      chk("lu_cnt", hz_cnt, 1);
      ex_valid = 0; ex_wreg = 0; ex_m2reg = 0;
      mem_valid = 1; mem_wreg = 1; mem_m2reg = 1; mem_dst = 4;
      mem_mo = 32'h1234; mem_mo_valid = 1;
      #1;
      chk("lu_fwd_sel", fwd_a, 3);
      chk("lu_fwd_val", d_a, 32'h1234);
      chk("lu_release", id_hold, 0);
      tick();
      chk("lu_e_valid", e_valid, 1);
      chk("lu_e_a", e_a, 32'h1234);
      chk("lu_e_dst", e_dst, 5);
      chk("lu_e_wreg", e_wreg, 1);

      // Slow load: three extra cycles without data
      idle(); cnt_clr = 1;
      tick(); cnt_clr = 0;
      chk("clr_cnt", hz_cnt, 0);
      ex_valid = 1; ex_wreg = 1; ex_m2reg = 1; ex_dst = 6;
      id_valid = 1; id_rt = 6; id_rt_used = 1;
      tick();
      ex_valid = 0; ex_wreg = 0; ex_m2reg = 0;
      mem_valid = 1; mem_wreg = 1; mem_m2reg = 1; mem_dst = 6; mem_mo_valid = 0;
      repeat (3) tick();
      mem_mo_valid = 1; mem_mo = 32'hCAFE;
      #1;
      chk("sl_cnt", hz_cnt, 4);
      chk("sl_release", id_hold, 0);
      chk("sl_fwd_sel", fwd_b, 3);
      chk("sl_fwd_val", d_b, 32'hCAFE);
      tick();
      chk("sl_e_b", e_b, 32'hCAFE);
      chk("sl_e_valid", e_valid, 1);

      // WB write-through, then RF read, then r0 stays zero
      idle();
      wb_wreg = 1; wb_dst = 7; wb_data = 32'hDEAD_BEEF;
      id_rs = 7; id_rs_used = 1;
      #1;
      chk("wb_bypass", d_a, 32'hDEAD_BEEF);
      tick(); wb_wreg = 0;
      #1;
      chk("wb_rf_read", d_a, 32'hDEAD_BEEF);
      wb_wreg = 1; wb_dst = 0; wb_data = 32'h55; id_rs = 0;
      #1;
      chk("r0_bypass", d_a, 0);
      tick(); wb_wreg = 0;
      #1;
      chk("r0_read", d_a, 0);

      // ex_stall with a hazard present holds the latch and the counter
      idle();
      id_valid = 1; id_wreg = 1; id_dst = 9; id_rs = 7; id_rs_used = 1;
      tick();
      chk("st_load_v", e_valid, 1);
      chk("st_load_a", e_a, 32'hDEAD_BEEF);
      ex_stall = 1; ex_valid = 1; ex_wreg = 1; ex_m2reg = 1; ex_dst = 7; id_dst = 10;
      #1;
      chk("st_hold", id_hold, 1);
      tick(); tick();
      chk("st_e_valid", e_valid, 1);
      chk("st_e_dst", e_dst, 9);
      chk("st_e_a", e_a, 32'hDEAD_BEEF);
      chk("st_cnt", hz_cnt, 4);
      flush = 1;
      tick();
      chk("st_flush_v", e_valid, 0);
      chk("st_flush_cnt", hz_cnt, 4);
      ex_stall = 0;
      tick();
      chk("flush_hz_cnt", hz_cnt, 4);
      chk("flush_hz_v", e_valid, 0);

      // Asynchronous reset in mid-pipeline
      idle();
      id_valid = 1; id_wreg = 1; id_m2reg = 1; id_dst = 3; id_rs = 7; id_rs_used = 1;
      tick();
      chk("pre_rst_v", e_valid, 1);
      chk("pre_rst_m2", e_m2reg, 1);
      rst = 0;
      #1;
      chk("arst_v", e_valid, 0);
      chk("arst_w", e_wreg, 0);
      chk("arst_m2", e_m2reg, 0);
      chk("arst_dst", e_dst, 0);
      chk("arst_a", e_a, 0);
      chk("arst_cnt", hz_cnt, 0);
      chk("arst_rf", d_a, 0);
      tick(); rst = 1;

      // Saturation of the 2-bit counter after five bubbles
      idle();
      ex_valid = 1; ex_wreg = 1; ex_m2reg = 1; ex_dst = 2;
      id_valid = 1; id_rs = 2; id_rs_used = 1;
      repeat (5) tick();
      chk("sat_cnt2", hz_cnt2, 3);
      chk("sat_cnt16", hz_cnt, 5);

      // Random traffic with occasional reset pulses
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst) rst = 1;
         rand_inputs();
         if ($urandom_range(0, 249) == 0) rst = 0;
      end

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
